id_pipe: RTL and testbench

- Parametrised, registered successor to the MIPS decode stage.
- Decodes one instruction per cycle and reads operands via the register-file read ports.
- Resolves RAW hazards by forwarding from NUM_FWD later stages (youngest wins); detects load-use hazards and requests a stall.
- Drives a registered ID/EX boundary with valid, downstream-stall hold and flush.

---
 rtl/id_pipe.sv | 241 ++++++++++++++++++++++++
 tb/tb_id_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_pipe.sv
// Registered MIPS decode stage: decodes one instruction per cycle, forwards operands
// from later stages (youngest wins), requests load-use stalls, drives the ID/EX register.
module id_pipe #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned NUM_FWD  = 2,
  parameter int unsigned ALUOP_W  = 8,
  parameter int unsigned ALUSEL_W = 3,
  parameter int unsigned PC_W     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inst_valid_i,
  input  logic [PC_W-1:0]           pc_i,
  input  logic [31:0]               inst_i,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  output logic                      reg1_read_o,
  output logic                      reg2_read_o,
  output logic [REG_AW-1:0]         reg1_addr_o,
  output logic [REG_AW-1:0]         reg2_addr_o,
  input  logic [NUM_FWD-1:0]        fwd_wreg_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
  input  logic                      ex_is_load_i,
  input  logic                      ex_stall_i,
  input  logic                      flush_i,
  output logic                      stall_req_o,
  output logic                      valid_o,
  output logic [ALUOP_W-1:0]        aluop_o,
  output logic [ALUSEL_W-1:0]       alusel_o,
  output logic [DATA_W-1:0]         reg1_o,
  output logic [DATA_W-1:0]         reg2_o,
  output logic [REG_AW-1:0]         wd_o,
  output logic                      wreg_o,
  output logic [PC_W-1:0]           pc_o,
  output logic                      inst_invalid_o
);

  // Primary opcodes
  localparam logic [5:0] OpcSpecial = 6'b000000;
  localparam logic [5:0] OpcAndi    = 6'b001100;
  localparam logic [5:0] OpcOri     = 6'b001101;
  localparam logic [5:0] OpcXori    = 6'b001110;
  localparam logic [5:0] OpcLui     = 6'b001111;
  localparam logic [5:0] OpcPref    = 6'b110011;

  // SPECIAL function codes
  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnSrl  = 6'b000010;
  localparam logic [5:0] FnSra  = 6'b000011;
  localparam logic [5:0] FnSllv = 6'b000100;
  localparam logic [5:0] FnSrlv = 6'b000110;
  localparam logic [5:0] FnSrav = 6'b000111;
  localparam logic [5:0] FnMovz = 6'b001010;
  localparam logic [5:0] FnMovn = 6'b001011;
  localparam logic [5:0] FnSync = 6'b001111;
  localparam logic [5:0] FnMfhi = 6'b010000;
  localparam logic [5:0] FnMthi = 6'b010001;
  localparam logic [5:0] FnMflo = 6'b010010;
  localparam logic [5:0] FnMtlo = 6'b010011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnXor  = 6'b100110;
  localparam logic [5:0] FnNor  = 6'b100111;

  // ALU operation encodings
  localparam logic [ALUOP_W-1:0] AluNop  = ALUOP_W'(8'b00000000);
  localparam logic [ALUOP_W-1:0] AluAnd  = ALUOP_W'(8'b00100100);
  localparam logic [ALUOP_W-1:0] AluOr   = ALUOP_W'(8'b00100101);
  localparam logic [ALUOP_W-1:0] AluXor  = ALUOP_W'(8'b00100110);
  localparam logic [ALUOP_W-1:0] AluNor  = ALUOP_W'(8'b00100111);
  localparam logic [ALUOP_W-1:0] AluSll  = ALUOP_W'(8'b01111100);
  localparam logic [ALUOP_W-1:0] AluSllv = ALUOP_W'(8'b00000100);
  localparam logic [ALUOP_W-1:0] AluSrl  = ALUOP_W'(8'b00000010);
  localparam logic [ALUOP_W-1:0] AluSrlv = ALUOP_W'(8'b00000110);
  localparam logic [ALUOP_W-1:0] AluSra  = ALUOP_W'(8'b00000011);
  localparam logic [ALUOP_W-1:0] AluSrav = ALUOP_W'(8'b00000111);
  localparam logic [ALUOP_W-1:0] AluMovz = ALUOP_W'(8'b00001010);
  localparam logic [ALUOP_W-1:0] AluMovn = ALUOP_W'(8'b00001011);
  localparam logic [ALUOP_W-1:0] AluMfhi = ALUOP_W'(8'b00010000);
  localparam logic [ALUOP_W-1:0] AluMthi = ALUOP_W'(8'b00010001);
  localparam logic [ALUOP_W-1:0] AluMflo = ALUOP_W'(8'b00010010);
  localparam logic [ALUOP_W-1:0] AluMtlo = ALUOP_W'(8'b00010011);

  // Result-select encodings
  localparam logic [ALUSEL_W-1:0] SelNop   = ALUSEL_W'(3'b000);
  localparam logic [ALUSEL_W-1:0] SelLogic = ALUSEL_W'(3'b001);
  localparam logic [ALUSEL_W-1:0] SelShift = ALUSEL_W'(3'b010);
  localparam logic [ALUSEL_W-1:0] SelMove  = ALUSEL_W'(3'b011);

  logic [5:0] opc, fn;
  logic [4:0] rs_f, rt_f, rd_f, sa_f;

  assign opc  = inst_i[31:26];
  assign rs_f = inst_i[25:21];
  assign rt_f = inst_i[20:16];
  assign rd_f = inst_i[15:11];
  assign sa_f = inst_i[10:6];
  assign fn   = inst_i[5:0];

  logic [ALUOP_W-1:0]  aluop_d;
  logic [ALUSEL_W-1:0] alusel_d;
  logic [REG_AW-1:0]   wd_d;
  logic [DATA_W-1:0]   imm;
  logic                rd1, rd2, wreg_base, invalid_d, is_movz, is_movn;

  always_comb begin
    aluop_d   = AluNop;
    alusel_d  = SelNop;
    wd_d      = REG_AW'(rd_f);
    imm       = '0;
    rd1       = 1'b0;
    rd2       = 1'b0;
    wreg_base = 1'b0;
    invalid_d = 1'b1;
    is_movz   = 1'b0;
    is_movn   = 1'b0;
    unique case (opc)
      OpcSpecial: begin
        if (fn == FnSll || fn == FnSrl || fn == FnSra) begin
          // Immediate shifts: shift amount travels on the port-1 operand
          if (rs_f == 5'd0) begin
            invalid_d = 1'b0;
            wreg_base = 1'b1;
            rd2       = 1'b1;
            alusel_d  = SelShift;
            imm       = DATA_W'(sa_f);
            aluop_d   = (fn == FnSll) ? AluSll : ((fn == FnSrl) ? AluSrl : AluSra);
          end
        end else if (sa_f == 5'd0) begin
          invalid_d = 1'b0;
          case (fn)
            FnOr:   begin wreg_base = 1'b1; rd1 = 1'b1; rd2 = 1'b1; aluop_d = AluOr;   alusel_d = SelLogic; end
            FnAnd:  begin wreg_base = 1'b1; rd1 = 1'b1; rd2 = 1'b1; aluop_d = AluAnd;  alusel_d = SelLogic; end
            FnXor:  begin wreg_base = 1'b1; rd1 = 1'b1; rd2 = 1'b1; aluop_d = AluXor;  alusel_d = SelLogic; end
            FnNor:  begin wreg_base = 1'b1; rd1 = 1'b1; rd2 = 1'b1; aluop_d = AluNor;  alusel_d = SelLogic; end
            FnSllv: begin wreg_base = 1'b1; rd1 = 1'b1; rd2 = 1'b1; aluop_d = AluSllv; alusel_d = SelShift; end
            FnSrlv: begin wreg_base = 1'b1; rd1 = 1'b1; rd2 = 1'b1; aluop_d = AluSrlv; alusel_d = SelShift; end
            FnSrav: begin wreg_base = 1'b1; rd1 = 1'b1; rd2 = 1'b1; aluop_d = AluSrav; alusel_d = SelShift; end
            FnMfhi: begin wreg_base = 1'b1; aluop_d = AluMfhi; alusel_d = SelMove; end
            FnMflo: begin wreg_base = 1'b1; aluop_d = AluMflo; alusel_d = SelMove; end
            FnMthi: begin rd1 = 1'b1; aluop_d = AluMthi; end
            FnMtlo: begin rd1 = 1'b1; aluop_d = AluMtlo; end
            FnMovz: begin rd1 = 1'b1; rd2 = 1'b1; is_movz = 1'b1; aluop_d = AluMovz; alusel_d = SelMove; end
            FnMovn: begin rd1 = 1'b1; rd2 = 1'b1; is_movn = 1'b1; aluop_d = AluMovn; alusel_d = SelMove; end
            FnSync: ;
            default: invalid_d = 1'b1;
          endcase
        end
      end
      OpcOri: begin
        invalid_d = 1'b0; wreg_base = 1'b1; rd1 = 1'b1; wd_d = REG_AW'(rt_f);
        aluop_d = AluOr; alusel_d = SelLogic; imm = DATA_W'(inst_i[15:0]);
      end
      OpcAndi: begin
        invalid_d = 1'b0; wreg_base = 1'b1; rd1 = 1'b1; wd_d = REG_AW'(rt_f);
        aluop_d = AluAnd; alusel_d = SelLogic; imm = DATA_W'(inst_i[15:0]);
      end
      OpcXori: begin
        invalid_d = 1'b0; wreg_base = 1'b1; rd1 = 1'b1; wd_d = REG_AW'(rt_f);
        aluop_d = AluXor; alusel_d = SelLogic; imm = DATA_W'(inst_i[15:0]);
      end
      OpcLui: begin
        invalid_d = 1'b0; wreg_base = 1'b1; rd1 = 1'b1; wd_d = REG_AW'(rt_f);
        aluop_d = AluOr; alusel_d = SelLogic; imm = DATA_W'({inst_i[15:0], 16'h0000});
      end
      OpcPref: invalid_d = 1'b0;
      default: ;
    endcase
  end

  assign reg1_read_o = rd1;
  assign reg2_read_o = rd2;
  assign reg1_addr_o = REG_AW'(rs_f);
  assign reg2_addr_o = REG_AW'(rt_f);

  // Forwarding: scan oldest to youngest so the lowest matching index wins
  logic [DATA_W-1:0] fwd1, fwd2, reg1_val, reg2_val;

  always_comb begin
    fwd1 = reg1_data_i;
    fwd2 = reg2_data_i;
    for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
      if (fwd_wreg_i[k] && (fwd_wd_i[k*REG_AW +: REG_AW] == reg1_addr_o)) begin
        fwd1 = fwd_wdata_i[k*DATA_W +: DATA_W];
      end
      if (fwd_wreg_i[k] && (fwd_wd_i[k*REG_AW +: REG_AW] == reg2_addr_o)) begin
        fwd2 = fwd_wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign reg1_val = !rd1 ? imm : ((reg1_addr_o == '0) ? '0 : fwd1);
  assign reg2_val = !rd2 ? imm : ((reg2_addr_o == '0) ? '0 : fwd2);

  logic wreg_d;
  assign wreg_d = (wreg_base || (is_movz && (reg2_val == '0)) || (is_movn && (reg2_val != '0)))
                  && (wd_d != '0);

  logic hit1, hit2;
  assign hit1 = rd1 && (reg1_addr_o != '0) && (reg1_addr_o == fwd_wd_i[0 +: REG_AW]);
  assign hit2 = rd2 && (reg2_addr_o != '0) && (reg2_addr_o == fwd_wd_i[0 +: REG_AW]);
  assign stall_req_o = inst_valid_i && ex_is_load_i && fwd_wreg_i[0] && (hit1 || hit2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o        <= 1'b0;
      aluop_o        <= '0;
      alusel_o       <= '0;
      reg1_o         <= '0;
      reg2_o         <= '0;
      wd_o           <= '0;
      wreg_o         <= 1'b0;
      pc_o           <= '0;
      inst_invalid_o <= 1'b0;
    end else if (flush_i) begin
      valid_o        <= 1'b0;
      wreg_o         <= 1'b0;
      inst_invalid_o <= 1'b0;
    end else if (!ex_stall_i) begin
      if (stall_req_o) begin
        // Bubble; upstream re-presents the same instruction next cycle
        valid_o        <= 1'b0;
        wreg_o         <= 1'b0;
        inst_invalid_o <= 1'b0;
      end else begin
        valid_o        <= inst_valid_i;
        aluop_o        <= aluop_d;
        alusel_o       <= alusel_d;
        reg1_o         <= reg1_val;
        reg2_o         <= reg2_val;
        wd_o           <= wd_d;
        wreg_o         <= wreg_d && inst_valid_i;
        pc_o           <= pc_i;
        inst_invalid_o <= invalid_d;
      end
    end
  end

endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe: reset, forwarding priority, r0, load-use, MOVZ/MOVN,
// stall/flush and decode corner cases.
module tb_id_pipe;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_FWD  = 2;
  localparam int unsigned ALUOP_W  = 8;
  localparam int unsigned ALUSEL_W = 3;
  localparam int unsigned PC_W     = 32;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      inst_valid_i;
  logic [PC_W-1:0]           pc_i;
  logic [31:0]               inst_i;
  logic [DATA_W-1:0]         reg1_data_i, reg2_data_i;
  logic                      reg1_read_o, reg2_read_o;
  logic [REG_AW-1:0]         reg1_addr_o, reg2_addr_o;
  logic [NUM_FWD-1:0]        fwd_wreg_i;
  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i;
  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i;
  logic                      ex_is_load_i, ex_stall_i, flush_i;
  logic                      stall_req_o, valid_o, wreg_o, inst_invalid_o;
  logic [ALUOP_W-1:0]        aluop_o;
  logic [ALUSEL_W-1:0]       alusel_o;
  logic [DATA_W-1:0]         reg1_o, reg2_o;
  logic [REG_AW-1:0]         wd_o;
  logic [PC_W-1:0]           pc_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_pipe #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD),
    .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W), .PC_W(PC_W)
  ) dut (
    .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .pc_i(pc_i), .inst_i(inst_i),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .ex_is_load_i(ex_is_load_i), .ex_stall_i(ex_stall_i), .flush_i(flush_i),
    .stall_req_o(stall_req_o), .valid_o(valid_o), .aluop_o(aluop_o), .alusel_o(alusel_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o),
    .inst_invalid_o(inst_invalid_o)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sa,
                                        input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_valid_i = 1'b1;
    pc_i         = '0;
    inst_i       = '0;
    reg1_data_i  = '0;
    reg2_data_i  = '0;
    fwd_wreg_i   = '0;
    fwd_wd_i     = '0;
    fwd_wdata_i  = '0;
    ex_is_load_i = 1'b0;
    ex_stall_i   = 1'b0;
    flush_i      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    #3;
    n_vec++;
    if ({valid_o, wreg_o, inst_invalid_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, pc_o} !== '0) begin
      n_err++;
      $display("FAIL reset_init valid=%b wreg=%b reg1=%h pc=%h required all zero",
               valid_o, wreg_o, reg1_o, pc_o);
    end
    step();
    rst    = 1'b1;
    pc_i   = 32'h100;
    inst_i = itype(6'b001101, 5'd0, 5'd3, 16'h00FF);
    step();
    n_vec++;
    if (valid_o !== 1'b1 || pc_o !== 32'h100 || reg2_o !== 32'hFF) begin
      n_err++;
      $display("FAIL reset_load valid=%b pc=%h reg2=%h required 1 00000100 000000ff",
               valid_o, pc_o, reg2_o);
    end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({valid_o, wreg_o, inst_invalid_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, pc_o} !== '0) begin
      n_err++;
      $display("FAIL reset_async valid=%b wreg=%b reg2=%h pc=%h required all zero",
               valid_o, wreg_o, reg2_o, pc_o);
    end
    #2 rst = 1'b1;
    step();
    n_vec++;
    if (valid_o !== 1'b1 || wreg_o !== 1'b1 || wd_o !== 5'd3 || reg2_o !== 32'hFF) begin
      n_err++;
      $display("FAIL reset_release valid=%b wreg=%b wd=%0d reg2=%h required 1 1 3 000000ff",
               valid_o, wreg_o, wd_o, reg2_o);
    end
  endtask

  task automatic test_fwd_priority();
    idle();
    inst_i      = itype(6'b001101, 5'd3, 5'd3, 16'h00FF);
    reg1_data_i = 32'hCAFE;
    fwd_wreg_i  = 2'b11;
    fwd_wd_i    = {5'd3, 5'd3};
    fwd_wdata_i = {32'h22, 32'h11};
    step();
    n_vec++;
    if (reg1_o !== 32'h11 || reg2_o !== 32'hFF || aluop_o !== 8'h25 || alusel_o !== 3'd1) begin
      n_err++;
      $display("FAIL fwd_src0 reg1=%h reg2=%h aluop=%h alusel=%0d required 11 ff 25 1",
               reg1_o, reg2_o, aluop_o, alusel_o);
    end
    fwd_wreg_i = 2'b10;
    step();
    n_vec++;
    if (reg1_o !== 32'h22) begin
      n_err++;
      $display("FAIL fwd_src1 reg1=%h required 00000022", reg1_o);
    end
    fwd_wreg_i = 2'b00;
    step();
    n_vec++;
    if (reg1_o !== 32'hCAFE) begin
      n_err++;
      $display("FAIL fwd_none reg1=%h required 0000cafe", reg1_o);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    inst_i       = rtype(5'd0, 5'd0, 5'd5, 5'd0, 6'b100101);
    reg1_data_i  = 32'h1234;
    reg2_data_i  = 32'h5678;
    fwd_wreg_i   = 2'b01;
    fwd_wd_i     = {5'd0, 5'd0};
    fwd_wdata_i  = {32'h0, 32'hDEAD};
    ex_is_load_i = 1'b1;
    #1;
    n_vec++;
    if (stall_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL zero_nostall stall_req=%b required 0", stall_req_o);
    end
    step();
    n_vec++;
    if (reg1_o !== 32'h0 || reg2_o !== 32'h0 || wreg_o !== 1'b1 || wd_o !== 5'd5) begin
      n_err++;
      $display("FAIL zero_operands reg1=%h reg2=%h wreg=%b wd=%0d required 0 0 1 5",
               reg1_o, reg2_o, wreg_o, wd_o);
    end
  endtask

  task automatic test_load_use();
    idle();
    inst_i       = rtype(5'd4, 5'd7, 5'd6, 5'd0, 6'b100100);
    reg1_data_i  = 32'h999;
    reg2_data_i  = 32'h77;
    ex_is_load_i = 1'b1;
    fwd_wreg_i   = 2'b01;
    fwd_wd_i     = {5'd0, 5'd4};
    #1;
    n_vec++;
    if (stall_req_o !== 1'b1) begin
      n_err++;
      $display("FAIL loaduse_req stall_req=%b required 1", stall_req_o);
    end
    step();
    n_vec++;
    if (valid_o !== 1'b0 || wreg_o !== 1'b0) begin
      n_err++;
      $display("FAIL loaduse_bubble valid=%b wreg=%b required 0 0", valid_o, wreg_o);
    end
    ex_is_load_i = 1'b0;
    fwd_wreg_i   = 2'b10;
    fwd_wd_i     = {5'd4, 5'd0};
    fwd_wdata_i  = {32'hF0, 32'h0};
    #1;
    n_vec++;
    if (stall_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL loaduse_release stall_req=%b required 0", stall_req_o);
    end
    step();
    n_vec++;
    if (reg1_o !== 32'hF0 || reg2_o !== 32'h77 || valid_o !== 1'b1 || wreg_o !== 1'b1 ||
        wd_o !== 5'd6 || aluop_o !== 8'h24) begin
      n_err++;
      $display("FAIL loaduse_replay reg1=%h reg2=%h valid=%b wreg=%b wd=%0d aluop=%h required f0 77 1 1 6 24",
               reg1_o, reg2_o, valid_o, wreg_o, wd_o, aluop_o);
    end
  endtask

  task automatic test_movzn();
    logic [5:0] fn_tab [4] = '{6'b001010, 6'b001010, 6'b001011, 6'b001011};
    logic [31:0] rt_tab [4] = '{32'h0, 32'h1, 32'h0, 32'h1};
    logic        exp_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    idle();
    reg1_data_i = 32'h5;
    reg2_data_i = 32'hAAAA;
    fwd_wreg_i  = 2'b01;
    fwd_wd_i    = {5'd0, 5'd8};
    for (int i = 0; i < 4; i++) begin
      inst_i      = rtype(5'd1, 5'd8, 5'd2, 5'd0, fn_tab[i]);
      fwd_wdata_i = {32'h0, rt_tab[i]};
      step();
      n_vec++;
      if (wreg_o !== exp_tab[i] || reg2_o !== rt_tab[i] || alusel_o !== 3'd3) begin
        n_err++;
        $display("FAIL movzn_%0d wreg=%b reg2=%h alusel=%0d required %b %h 3",
                 i, wreg_o, reg2_o, alusel_o, exp_tab[i], rt_tab[i]);
      end
    end
  endtask

  task automatic test_stall_flush();
    idle();
    pc_i        = 32'h200;
    inst_i      = rtype(5'd1, 5'd2, 5'd9, 5'd0, 6'b100110);
    reg1_data_i = 32'hA5;
    reg2_data_i = 32'h5A;
    step();
    pc_i        = 32'h300;
    inst_i      = rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'b100101);
    reg1_data_i = 32'h1;
    ex_stall_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (valid_o !== 1'b1 || aluop_o !== 8'h26 || reg1_o !== 32'hA5 || wd_o !== 5'd9 ||
          pc_o !== 32'h200) begin
        n_err++;
        $display("FAIL stall_hold_%0d valid=%b aluop=%h reg1=%h wd=%0d pc=%h required 1 26 a5 9 200",
                 i, valid_o, aluop_o, reg1_o, wd_o, pc_o);
      end
    end
    flush_i = 1'b1;
    step();
    n_vec++;
    if (valid_o !== 1'b0 || wreg_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_over_stall valid=%b wreg=%b required 0 0", valid_o, wreg_o);
    end
    idle();
    inst_i = 32'hFC00_0000 | rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100101);
    step();
    n_vec++;
    if (inst_invalid_o !== 1'b1 || wreg_o !== 1'b0 || valid_o !== 1'b1 || aluop_o !== 8'h0 ||
        alusel_o !== 3'd0) begin
      n_err++;
      $display("FAIL invalid_op inv=%b wreg=%b valid=%b aluop=%h alusel=%0d required 1 0 1 00 0",
               inst_invalid_o, wreg_o, valid_o, aluop_o, alusel_o);
    end
    inst_i       = rtype(5'd4, 5'd7, 5'd6, 5'd0, 6'b100100);
    ex_is_load_i = 1'b1;
    fwd_wreg_i   = 2'b01;
    fwd_wd_i     = {5'd0, 5'd4};
    flush_i      = 1'b1;
    #1;
    n_vec++;
    if (stall_req_o !== 1'b1) begin
      n_err++;
      $display("FAIL flush_stallreq stall_req=%b required 1", stall_req_o);
    end
    step();
    n_vec++;
    if (valid_o !== 1'b0 || wreg_o !== 1'b0 || inst_invalid_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_with_loaduse valid=%b wreg=%b inv=%b required 0 0 0",
               valid_o, wreg_o, inst_invalid_o);
    end
  endtask

  task automatic test_decode_misc();
    idle();
    inst_i      = rtype(5'd0, 5'd11, 5'd10, 5'd5, 6'b000000);
    reg2_data_i = 32'h3;
    step();
    n_vec++;
    if (aluop_o !== 8'h7C || alusel_o !== 3'd2 || reg1_o !== 32'h5 || reg2_o !== 32'h3 ||
        wd_o !== 5'd10 || wreg_o !== 1'b1) begin
      n_err++;
      $display("FAIL sll aluop=%h alusel=%0d reg1=%h reg2=%h wd=%0d wreg=%b required 7c 2 5 3 10 1",
               aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o);
    end
    inst_i = rtype(5'd3, 5'd11, 5'd10, 5'd5, 6'b000000);
    step();
    n_vec++;
    if (inst_invalid_o !== 1'b1 || wreg_o !== 1'b0) begin
      n_err++;
      $display("FAIL sll_rs_nonzero inv=%b wreg=%b required 1 0", inst_invalid_o, wreg_o);
    end
    inst_i      = itype(6'b001111, 5'd0, 5'd1, 16'h1234);
    reg1_data_i = 32'hFFFF;
    step();
    n_vec++;
    if (reg1_o !== 32'h0 || reg2_o !== 32'h1234_0000 || aluop_o !== 8'h25 || wd_o !== 5'd1 ||
        wreg_o !== 1'b1) begin
      n_err++;
      $display("FAIL lui reg1=%h reg2=%h aluop=%h wd=%0d wreg=%b required 0 12340000 25 1 1",
               reg1_o, reg2_o, aluop_o, wd_o, wreg_o);
    end
    inst_i = rtype(5'd0, 5'd0, 5'd0, 5'd0, 6'b001111);
    step();
    n_vec++;
    if (wreg_o !== 1'b0 || aluop_o !== 8'h0 || inst_invalid_o !== 1'b0 || valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL sync wreg=%b aluop=%h inv=%b valid=%b required 0 00 0 1",
               wreg_o, aluop_o, inst_invalid_o, valid_o);
    end
    inst_i       = itype(6'b001101, 5'd0, 5'd3, 16'h0001);
    inst_valid_i = 1'b0;
    step();
    n_vec++;
    if (valid_o !== 1'b0 || wreg_o !== 1'b0) begin
      n_err++;
      $display("FAIL inst_not_valid valid=%b wreg=%b required 0 0", valid_o, wreg_o);
    end
  endtask

  initial begin
    test_reset();
    test_fwd_priority();
    test_zero_reg();
    test_load_use();
    test_movzn();
    test_stall_flush();
    test_decode_misc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
